// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the counter / bit-reversal / serializer chain.
package bit_serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serializer_frame_counter.sv
// Wrapping count of completed frames with a one-cycle pulse on wrap.
module frame_counter
    import bit_serializer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ov
);

    // Count enabled increments; flag the all-ones to zero transition for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ov    <= 1'b0;
        end else begin
            ov <= inc && (count == '1);
            if (inc) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with load/ready handshake, frame strobe,
// end-of-frame pulse and a wrapping frames-sent counter.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 serial_out,
    output logic                 frame,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 OV
);

    localparam int unsigned BC_W    = $clog2(WIDTH);
    localparam int unsigned OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    state_t            state, state_nx;
    logic [WIDTH-1:0]  sreg, sreg_nx;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_nx;
    logic              frame_end;

    // State, shift register and bit counter; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    // Next-state logic: accept in IDLE/DONE, shift in SHIFT, one DONE cycle per frame.
    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        frame_end  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    sreg_nx    = data_in;
                    bit_cnt_nx = '0;
                    state_nx   = SHIFT;
                end else begin
                    state_nx   = IDLE;
                end
            end
            SHIFT: begin
                sreg_nx    = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg[WIDTH-1:1]};
                bit_cnt_nx = bit_cnt + BC_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    state_nx  = DONE;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; the shift register is zero-filled,
    // so serial_out returns to 0 once a frame has fully drained.
    assign ready      = (state != SHIFT);
    assign frame      = (state == SHIFT);
    assign done       = (state == DONE);
    assign serial_out = sreg[OUT_BIT];

    // The counter advances on the edge entering DONE, so word_cnt and OV are
    // already updated during the done cycle.
    frame_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_frame_counter (
        .clk  (clk),
        .rst  (Reset),
        .inc  (frame_end),
        .count(word_cnt),
        .ov   (OV)
    );

endmodule
